// File: rtl/mcu_playlist.sv
// ---------------------------------------------------------------------------
// mcu_playlist
//
// Playlist control unit. It owns the play/pause state and the current song
// index for a playlist of NUM_SONGS songs. It sits between the one-pulsed
// front-panel buttons and the song reader / note player.
//
// Parameters
//   NUM_SONGS : number of songs in the playlist (>= 2)
//   SONG_W    : song index width, 2^(SONG_W-1) < NUM_SONGS <= 2^SONG_W,
//               SONG_W <= 8 (shuffle candidates come from an 8-bit LFSR)
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   reset        : asynchronous, active-low reset
//   play_button  : one-cycle pulse, toggles play/pause
//   next_button  : one-cycle pulse, advance to the next song
//   prev_button  : one-cycle pulse, go back one song
//   mode         : playback mode, used combinationally in the same cycle
//                  00 stop-at-end, 01 repeat-all, 10 repeat-one, 11 shuffle
//   song_done    : one-cycle pulse from the player at the end of a song
//   play         : 1 = playing, 0 = paused (registered)
//   reset_player : one-cycle pulse in the first cycle of a new or restarted
//                  song (registered)
//   song         : current song index 0..NUM_SONGS-1 (registered)
// ---------------------------------------------------------------------------
module mcu_playlist #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic [1:0]        mode,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song
);

  localparam logic [0:0] PAUSED  = 1'b0;
  localparam logic [0:0] PLAYING = 1'b1;

  localparam logic [1:0] SEQ_STOP   = 2'b00;
  localparam logic [1:0] REPEAT_ALL = 2'b01;
  localparam logic [1:0] REPEAT_ONE = 2'b10;
  localparam logic [1:0] SHUFFLE    = 2'b11;

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [SONG_W:0]   NUM_EXT   = (SONG_W + 1)'(NUM_SONGS);
  localparam logic [7:0]        LFSR_SEED = 8'h01;

  function automatic logic [SONG_W-1:0] inc_song(input logic [SONG_W-1:0] s);
    return (s == LAST_SONG) ? '0 : s + SONG_W'(1);
  endfunction

  function automatic logic [SONG_W-1:0] dec_song(input logic [SONG_W-1:0] s);
    return (s == '0) ? LAST_SONG : s - SONG_W'(1);
  endfunction

  // Fold the random candidate into range with a single subtraction (valid
  // because NUM_SONGS is more than half the index space), then bump it off
  // the current song so a shuffle always moves somewhere new.
  function automatic logic [SONG_W-1:0] shuffle_pick(
    input logic [SONG_W-1:0] cur,
    input logic [SONG_W-1:0] rnd
  );
    logic [SONG_W-1:0] c;
    c = rnd;
    if ({1'b0, c} >= NUM_EXT) c = c - NUM_EXT[SONG_W-1:0];
    if (c == cur) c = inc_song(cur);
    return c;
  endfunction

  logic [0:0]        state_p1;
  logic [SONG_W-1:0] song_p1;
  logic              pulse_p1;
  logic [7:0]        lfsr_p1;

  logic [0:0]        state_p0;
  logic [SONG_W-1:0] song_p0;
  logic              pulse_p0;
  logic              lfsr_fb;
  logic [SONG_W-1:0] song_inc;
  logic [SONG_W-1:0] song_dec;
  logic [SONG_W-1:0] song_shuf;

  // ---- stage 0: event arbitration and next-state ----
  assign lfsr_fb   = lfsr_p1[7] ^ lfsr_p1[5] ^ lfsr_p1[4] ^ lfsr_p1[3];
  assign song_inc  = inc_song(song_p1);
  assign song_dec  = dec_song(song_p1);
  assign song_shuf = shuffle_pick(song_p1, lfsr_p1[SONG_W-1:0]);

  // Priority next > prev > song_done > play_button. A lower-priority event
  // in the same cycle is dropped even when the winner has no effect (e.g.
  // song_done while paused).
  always_comb begin
    state_p0 = state_p1;
    song_p0  = song_p1;
    pulse_p0 = 1'b0;
    if (next_button) begin
      song_p0  = (mode == SHUFFLE) ? song_shuf : song_inc;
      pulse_p0 = 1'b1;
    end else if (prev_button) begin
      song_p0  = song_dec;
      pulse_p0 = 1'b1;
    end else if (song_done) begin
      if (state_p1 == PLAYING) begin
        pulse_p0 = 1'b1;
        case (mode)
          SEQ_STOP: begin
            song_p0 = song_inc;
            if (song_p1 == LAST_SONG) state_p0 = PAUSED;
          end
          REPEAT_ALL: song_p0 = song_inc;
          REPEAT_ONE: song_p0 = song_p1;
          default:    song_p0 = song_shuf;
        endcase
      end
    end else if (play_button) begin
      state_p0 = (state_p1 == PLAYING) ? PAUSED : PLAYING;
    end
  end

  // ---- stage 1: registered outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1 <= PAUSED;
      song_p1  <= '0;
      pulse_p1 <= 1'b0;
      lfsr_p1  <= LFSR_SEED;
    end else begin
      state_p1 <= state_p0;
      song_p1  <= song_p0;
      pulse_p1 <= pulse_p0;
      lfsr_p1  <= {lfsr_p1[6:0], lfsr_fb};
    end
  end

  assign play         = (state_p1 == PLAYING);
  assign reset_player = pulse_p1;
  assign song         = song_p1;

endmodule
